bst_update_ctrl: RTL
====================

# bst_update_ctrl

Branch-resolution side of the branch status table (BST). Tracks every prediction the BST issued at fetch in a small in-order FIFO. When the execute stage resolves the oldest branch, the block computes the next 2-bit status and drives the BST write port (`en_1`, `status_update`, `PC_update`, `PC_predict_update`). It also flags mispredictions with a redirect PC and flushes wrong-path entries.

## Interface
- `DEPTH`, 4: in-flight prediction capacity; power of two, ≥2.
- `clk`  in  1  single clock; all state on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  BST lookup result presented this cycle.
- `fetch_pc`  in  32  PC that was looked up.
- `fetch_status`  in  2  BST `status` output; 0 = miss.
- `fetch_target`  in  32  BST `PC_predict_o`.
- `fetch_ready`  out  1  FIFO not full (combinational from count).
- `res_valid`  in  1  oldest in-flight instruction resolved this cycle.
- `res_pc`  in  32  PC of resolved instruction.
- `res_is_branch`  in  1  resolved instruction is a branch/jump.
- `res_taken`  in  1  actual direction.
- `res_target`  in  32  actual taken target.
- `flush`  in  1  external pipeline flush.
- `en_1`  out  1  BST write strobe, one-cycle pulse.
- `status_update`  out  2  status to write.
- `PC_update`  out  32  tag/index PC to write.
- `PC_predict_update`  out  32  target to write.
- `mispredict`  out  1  one-cycle pulse.
- `redirect_pc`  out  32  correct next PC, valid with `mispredict`.
- `seq_err`  out  1  sticky protocol-error flag.

## Operation
- FIFO entry: {pc, status, target}. Push on `fetch_valid & fetch_ready`. Pop on `res_valid` when count≠0.
- Status encoding: 0 invalid, 1 not-taken, 2 weak-taken, 3 strong-taken. Predicted taken = status≥2; a miss (0) predicts not-taken, fall-through.
- Update rule on pop, with entry.pc == `res_pc`:
  - Branch, taken: status 0→2, 1→2, 2→3, 3→3. Write `PC_predict_update`=`res_target`.
  - Branch, not taken: 3→2, 2→1, 1→1. Write `PC_predict_update`=entry.target.
  - Branch, not taken, status 0: no write. Not-taken branches are never allocated.
  - Non-branch with status≠0 (alias): write status 0, target entry.target.
  - Non-branch with status 0: no write.
  - Every write sets `PC_update`=`res_pc`.
- Mispredict on pop when any of the following holds:
  - taken and (predicted not-taken or entry.target≠`res_target`): `redirect_pc`=`res_target`.
  - not taken (or non-branch) and predicted taken: `redirect_pc`=`res_pc`+4, 32-bit wrap.
- Mispredict clears the FIFO at the same edge that pops the entry. Any same-cycle push is discarded.
- `flush` clears the FIFO at the next edge. It overrides push, pop and any same-cycle resolution: no write, no mispredict.
- Error cases set `seq_err`, which is cleared only by `rst`. In each case no write and no mispredict occur.
  - `res_valid` with FIFO empty.
  - entry.pc≠`res_pc`; the entry is still popped.
  - `fetch_valid` while full; the push is dropped.
- Push and pop in the same cycle are allowed at any count except when a mispredict or flush clears the FIFO. When full, `fetch_ready`=0 even if a pop is also present that cycle.

## Timing
- Resolution accepted in cycle N → `en_1`, `status_update`, `PC_update`, `PC_predict_update`, `mispredict`, `redirect_pc` registered and valid in cycle N+1 for exactly one cycle. Outside these pulses `en_1`=0 and `mispredict`=0; the data outputs hold their last value.
- FIFO count updates at the edge ending cycle N. An entry pushed in cycle N can be resolved in cycle N+1 at the earliest.
- Back-to-back resolutions give back-to-back write pulses, one per cycle.
- Reset (`rst`=0, asynchronous, immediate):
  - All outputs go to 0, FIFO is emptied, `seq_err`=0.
  - `fetch_ready`=1 once count=0.
  - Takes effect mid-operation, including mid-pulse.
- Count width is clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0, `fetch_ready`=1. Release, idle 3 cycles → no `en_1`.
- Cold miss, taken: push pc=0x100, status=0, target=0. Resolve taken to 0x200 → next cycle `en_1`=1, `status_update`=2, `PC_update`=0x100, `PC_predict_update`=0x200, `mispredict`=1, `redirect_pc`=0x200.
- Correct strong hit: push status=3, target=0x200. Resolve taken to 0x200 → `en_1`=1, `status_update`=3, `mispredict`=0.
- Wrong-path flush: push pc=0x100 (status=2, target=0x200), then 0x104 and 0x108. Resolve 0x100 not taken → `status_update`=1, `redirect_pc`=0x104, `mispredict`=1. FIFO empty next cycle, so a following `res_valid` sets `seq_err`.
- Full: push 4 entries with no resolve → `fetch_ready`=0. A 5th `fetch_valid` is dropped and sets `seq_err`=1. Then 4 resolutions give 4 consecutive `en_1` pulses in order.
- Async reset mid-pulse: assert `rst`=0 in the cycle `en_1`=1 → `en_1`, `mispredict` and `seq_err` drop to 0 immediately, before the next edge.

Source files
------------

// File: rtl/bst_update_ctrl.sv
// ---------------------------------------------------------------------------
// bst_update_ctrl
//   Resolution side of the branch status table (BST). Every BST lookup made
//   at fetch is queued in a small in-order FIFO. When execute resolves the
//   oldest instruction, the matching entry is popped. The next 2-bit status
//   is computed and written back through the BST write port. Mispredictions
//   raise a redirect and discard the wrong-path entries.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   fetch_valid/pc/status/target   BST lookup result to enqueue
//   fetch_ready         FIFO not full
//   res_valid/pc/is_branch/taken/target   resolution of the oldest entry
//   flush               external pipeline flush (clears FIFO, suppresses all)
//   en_1, status_update, PC_update, PC_predict_update   BST write port
//   mispredict, redirect_pc   one-cycle redirect pulse and correct next PC
//   seq_err             sticky protocol-error flag
// ---------------------------------------------------------------------------
module bst_update_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [1:0]  fetch_status,
    input  logic [31:0] fetch_target,
    output logic        fetch_ready,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_is_branch,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        flush,
    output logic        en_1,
    output logic [1:0]  status_update,
    output logic [31:0] PC_update,
    output logic [31:0] PC_predict_update,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        seq_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Saturating 2-bit update. A miss (0) that resolves taken allocates as
    // weak-taken. A not-taken resolution never drops below not-taken (1).
    function automatic logic [1:0] next_status(input logic [1:0] st, input logic taken);
        logic [1:0] ns;
        case ({taken, st})
            3'b1_00: ns = 2'd2;
            3'b1_01: ns = 2'd2;
            3'b1_10: ns = 2'd3;
            3'b1_11: ns = 2'd3;
            3'b0_11: ns = 2'd2;
            3'b0_10: ns = 2'd1;
            3'b0_01: ns = 2'd1;
            3'b0_00: ns = 2'd0;
            default: ns = 2'd0;
        endcase
        return ns;
    endfunction

    logic [31:0]   pc_mem_r [DEPTH];
    logic [1:0]    st_mem_r [DEPTH];
    logic [31:0]   tg_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          en_1_r;
    logic [1:0]    status_update_r;
    logic [31:0]   pc_update_r;
    logic [31:0]   pc_predict_update_r;
    logic          mispredict_r;
    logic [31:0]   redirect_pc_r;
    logic          seq_err_r;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          clear_s;
    logic          match_s;
    logic          pred_taken_s;
    logic [31:0]   head_pc_s;
    logic [1:0]    head_st_s;
    logic [31:0]   head_tg_s;
    logic          wr_s;
    logic [1:0]    new_st_s;
    logic [31:0]   new_tg_s;
    logic          misp_s;
    logic [31:0]   redir_s;
    logic          err_s;

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign fetch_ready = !full_s;

    // Resolution decode: write-back value, mispredict and protocol errors.
    always_comb begin
        head_pc_s    = pc_mem_r[rd_ptr_r];
        head_st_s    = st_mem_r[rd_ptr_r];
        head_tg_s    = tg_mem_r[rd_ptr_r];
        pop_s        = res_valid && !empty_s;
        match_s      = (head_pc_s == res_pc);
        pred_taken_s = head_st_s[1];
        wr_s         = 1'b0;
        new_st_s     = 2'd0;
        new_tg_s     = head_tg_s;
        misp_s       = 1'b0;
        redir_s      = res_pc + 32'd4;

        if (!flush && pop_s && match_s) begin
            if (res_is_branch && res_taken) begin
                wr_s     = 1'b1;
                new_st_s = next_status(head_st_s, 1'b1);
                new_tg_s = res_target;
                if (!pred_taken_s || (head_tg_s != res_target)) begin
                    misp_s  = 1'b1;
                    redir_s = res_target;
                end else begin
                    misp_s  = 1'b0;
                end
            end else if (res_is_branch) begin
                // A not-taken miss is never allocated.
                wr_s     = (head_st_s != 2'd0);
                new_st_s = next_status(head_st_s, 1'b0);
                misp_s   = pred_taken_s;
            end else begin
                // Non-branch that hit in the BST is an alias: invalidate it.
                wr_s     = (head_st_s != 2'd0);
                new_st_s = 2'd0;
                misp_s   = pred_taken_s;
            end
        end else begin
            wr_s   = 1'b0;
            misp_s = 1'b0;
        end

        if (!flush) begin
            err_s = (res_valid && empty_s) ||
                    (pop_s && !match_s) ||
                    (fetch_valid && full_s);
        end else begin
            err_s = 1'b0;
        end

        clear_s = flush || misp_s;
        push_s  = fetch_valid && !full_s && !clear_s;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i] <= 32'd0;
                st_mem_r[i] <= 2'd0;
                tg_mem_r[i] <= 32'd0;
            end
        end else if (clear_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r] <= fetch_pc;
                st_mem_r[wr_ptr_r] <= fetch_status;
                tg_mem_r[wr_ptr_r] <= fetch_target;
                wr_ptr_r           <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Registered write-port / redirect pulses. Data outputs hold between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_1_r              <= 1'b0;
            status_update_r     <= 2'd0;
            pc_update_r         <= 32'd0;
            pc_predict_update_r <= 32'd0;
            mispredict_r        <= 1'b0;
            redirect_pc_r       <= 32'd0;
            seq_err_r           <= 1'b0;
        end else begin
            en_1_r       <= wr_s;
            mispredict_r <= misp_s;
            if (wr_s) begin
                status_update_r     <= new_st_s;
                pc_update_r         <= res_pc;
                pc_predict_update_r <= new_tg_s;
            end
            if (misp_s) begin
                redirect_pc_r <= redir_s;
            end
            if (err_s) begin
                seq_err_r <= 1'b1;
            end
        end
    end

    assign en_1              = en_1_r;
    assign status_update     = status_update_r;
    assign PC_update         = pc_update_r;
    assign PC_predict_update = pc_predict_update_r;
    assign mispredict        = mispredict_r;
    assign redirect_pc       = redirect_pc_r;
    assign seq_err           = seq_err_r;

endmodule
